uart_register_loader: RTL and testbench

Serial front end for the APU project: it receives 8N1 UART frames on the RX pin and turns byte pairs into APU register writes. It oversamples `rx` using a one-cycle 16x baud enable from the prescaler, checks start and stop bits, and pairs an address byte with the data byte that follows it. It sits between the board RX pin and the APU register file, which consumes `we`/`addr`/`wdata`.

---
 rtl/uart_register_loader_if.sv | 22 ++
 rtl/uart_register_loader.sv | 146 ++++++++++++++
 tb/tb_uart_register_loader.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/uart_register_loader_if.sv
// Bundle between the baud prescaler / RX pin and the APU register file.
interface uart_register_loader_if;
    logic       baud_en;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic [4:0] addr;
    logic [7:0] wdata;
    logic       we;
    logic       busy;

    modport master (
        output baud_en, rx,
        input  data, valid, frame_err, addr, wdata, we, busy
    );

    modport slave (
        input  baud_en, rx,
        output data, valid, frame_err, addr, wdata, we, busy
    );
endinterface

// File: rtl/uart_register_loader.sv
// 8N1 UART receiver that pairs an address byte (100a_aaaa) with the next
// data byte and issues one APU register write.
//   state | meaning
//   IDLE  | waiting for a low rx sample on a baud tick
//   START | counting to mid start bit, rejecting glitches
//   DATA  | sampling 8 data bits at mid bit, LSB first
//   STOP  | sampling stop bit, then straight back to IDLE
module uart_register_loader #(
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    uart_register_loader_if.slave bus
);

    localparam int TCW = (OVERSAMPLE > 16) ? $clog2(OVERSAMPLE) : 4;
    localparam logic [TCW-1:0] TC_HALF = TCW'(OVERSAMPLE / 2 - 1);
    localparam logic [TCW-1:0] TC_FULL = TCW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t         state, state_nx;
    logic           rx_m, rx_s;
    logic [TCW-1:0] tc, tc_nx;
    logic [2:0]     bc, bc_nx;
    logic [7:0]     shreg, shreg_nx;
    logic           byte_done, byte_ok;
    logic           pending;
    logic [4:0]     addr_q;
    logic           is_addr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= bus.rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            tc    <= '0;
            bc    <= '0;
            shreg <= '0;
        end else begin
            state <= state_nx;
            tc    <= tc_nx;
            bc    <= bc_nx;
            shreg <= shreg_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        tc_nx     = tc;
        bc_nx     = bc;
        shreg_nx  = shreg;
        byte_done = 1'b0;
        byte_ok   = 1'b0;
        if (bus.baud_en) begin
            case (state)
                IDLE: begin
                    if (!rx_s) begin
                        state_nx = START;
                        tc_nx    = '0;
                    end
                end
                START: begin
                    if (tc == TC_HALF) begin
                        tc_nx    = '0;
                        bc_nx    = '0;
                        state_nx = rx_s ? IDLE : DATA;
                    end else begin
                        tc_nx = tc + 1'b1;
                    end
                end
                DATA: begin
                    if (tc == TC_FULL) begin
                        tc_nx        = '0;
                        shreg_nx[bc] = rx_s;
                        if (bc == 3'd7) state_nx = STOP;
                        else            bc_nx    = bc + 1'b1;
                    end else begin
                        tc_nx = tc + 1'b1;
                    end
                end
                STOP: begin
                    // Leaving at mid stop bit leaves half a bit to catch a
                    // back-to-back start edge.
                    if (tc == TC_FULL) begin
                        tc_nx     = '0;
                        state_nx  = IDLE;
                        byte_done = 1'b1;
                        byte_ok   = rx_s;
                    end else begin
                        tc_nx = tc + 1'b1;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign is_addr = (shreg[7:5] == 3'b100);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.data      <= '0;
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.addr      <= '0;
            bus.wdata     <= '0;
            bus.we        <= 1'b0;
            pending       <= 1'b0;
            addr_q        <= '0;
        end else begin
            bus.valid     <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.we        <= 1'b0;
            if (byte_done) begin
                if (byte_ok) begin
                    bus.data  <= shreg;
                    bus.valid <= 1'b1;
                    if (is_addr) begin
                        addr_q  <= shreg[4:0];
                        pending <= 1'b1;
                    end else if (pending) begin
                        bus.addr  <= addr_q;
                        bus.wdata <= shreg;
                        bus.we    <= 1'b1;
                        pending   <= 1'b0;
                    end
                end else begin
                    bus.frame_err <= 1'b1;
                    pending       <= 1'b0;
                end
            end
        end
    end

    assign bus.busy = (state != IDLE);

endmodule

// File: tb/tb_uart_register_loader.sv
// Directed bench: serial frames in, register writes and strobes checked
// against hand-computed values.
module tb_uart_register_loader;

    localparam int OS       = 16;
    localparam int DIV      = 4;
    localparam int BIT_CLKS = OS * DIV;

    logic clk;
    logic rst;
    uart_register_loader_if bus();

    uart_register_loader #(.OVERSAMPLE(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  vq[$];
    logic [12:0] wq[$];
    int          fe_cnt    = 0;
    logic [7:0]  fe_data   = '0;
    logic        busy_seen = 1'b0;
    int          bad_width = 0;
    int          overlap   = 0;
    int          we_orphan = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] vq_at(input int i);
        return (i < vq.size()) ? 32'(vq[i]) : 32'hDEAD;
    endfunction

    function automatic logic [31:0] wq_at(input int i);
        return (i < wq.size()) ? 32'(wq[i]) : 32'hDEAD;
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        int cnt;
        cnt = 0;
        bus.baud_en = 1'b0;
        forever begin
            @(negedge clk);
            cnt = (cnt == DIV - 1) ? 0 : cnt + 1;
            bus.baud_en = (cnt == 0);
        end
    end

    initial begin
        logic pv, pw, pf;
        pv = 1'b0; pw = 1'b0; pf = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.valid) vq.push_back(bus.data);
            if (bus.we) wq.push_back({bus.addr, bus.wdata});
            if (bus.frame_err) begin
                fe_cnt++;
                fe_data = bus.data;
            end
            if (bus.busy) busy_seen = 1'b1;
            if ((bus.valid && pv) || (bus.we && pw) || (bus.frame_err && pf)) bad_width++;
            if (bus.valid && bus.frame_err) overlap++;
            if (bus.we && !bus.valid) we_orphan++;
            pv = bus.valid; pw = bus.we; pf = bus.frame_err;
        end
    end

    task automatic clear_mon();
        vq.delete();
        wq.delete();
        fe_cnt    = 0;
        busy_seen = 1'b0;
    endtask

    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * BIT_CLKS) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"},  32'(bus.data),      32'h0);
        check({tag, "_valid"}, 32'(bus.valid),     32'h0);
        check({tag, "_ferr"},  32'(bus.frame_err), 32'h0);
        check({tag, "_addr"},  32'(bus.addr),      32'h0);
        check({tag, "_wdata"}, 32'(bus.wdata),     32'h0);
        check({tag, "_we"},    32'(bus.we),        32'h0);
        check({tag, "_busy"},  32'(bus.busy),      32'h0);
    endtask

    initial begin
        rst    = 1'b1;
        bus.rx = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        idle_bits(1);

        // address 0x85 then data 0x3C
        clear_mon();
        send_frame(8'h85, 1'b1);
        idle_bits(1);
        send_frame(8'h3C, 1'b1);
        idle_bits(2);
        check("pair_nvalid", vq.size(), 2);
        check("pair_data0",  vq_at(0), 32'h85);
        check("pair_data1",  vq_at(1), 32'h3C);
        check("pair_nwe",    wq.size(), 1);
        check("pair_write",  wq_at(0), {19'h0, 5'd5, 8'h3C});
        check("pair_addr",   32'(bus.addr),  32'd5);
        check("pair_wdata",  32'(bus.wdata), 32'h3C);
        check("pair_ferr",   fe_cnt, 0);

        // start-bit glitch of 4 ticks
        clear_mon();
        bus.rx = 1'b0;
        repeat (4 * DIV) @(negedge clk);
        bus.rx = 1'b1;
        repeat (8 * DIV) @(negedge clk);
        check("glitch_busy_seen", 32'(busy_seen), 32'h1);
        check("glitch_busy_idle", 32'(bus.busy),  32'h0);
        idle_bits(1);
        check("glitch_nvalid", vq.size(), 0);
        check("glitch_ferr",   fe_cnt, 0);
        check("glitch_data",   32'(bus.data), 32'h3C);

        // 0x91 with bad stop bit, then 0x22
        clear_mon();
        send_frame(8'h91, 1'b0);
        idle_bits(2);
        check("ferr_count", fe_cnt, 1);
        check("ferr_data_kept", 32'(fe_data), 32'h3C);
        check("ferr_nvalid", vq.size(), 0);
        send_frame(8'h22, 1'b1);
        idle_bits(2);
        check("ferr_next_nvalid", vq.size(), 1);
        check("ferr_next_data",   vq_at(0), 32'h22);
        check("ferr_next_nwe",    wq.size(), 0);

        // back-to-back address, address, data
        clear_mon();
        send_frame(8'h82, 1'b1);
        send_frame(8'h9F, 1'b1);
        send_frame(8'h7E, 1'b1);
        idle_bits(2);
        check("b2b_nvalid", vq.size(), 3);
        check("b2b_data2",  vq_at(2), 32'h7E);
        check("b2b_nwe",    wq.size(), 1);
        check("b2b_write",  wq_at(0), {19'h0, 5'h1F, 8'h7E});
        check("b2b_ferr",   fe_cnt, 0);

        // reset in the middle of 0x83
        clear_mon();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        check("mid_busy", 32'(bus.busy), 32'h1);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check_all_zero("midrst");
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle_bits(2);
        check("midrst_nvalid", vq.size(), 0);
        clear_mon();
        send_frame(8'h84, 1'b1);
        send_frame(8'h11, 1'b1);
        idle_bits(2);
        check("midrst_nvalid2", vq.size(), 2);
        check("midrst_nwe",     wq.size(), 1);
        check("midrst_write",   wq_at(0), {19'h0, 5'd4, 8'h11});

        // lone data byte
        clear_mon();
        send_frame(8'h55, 1'b1);
        idle_bits(2);
        check("lone_nvalid", vq.size(), 1);
        check("lone_data",   vq_at(0), 32'h55);
        check("lone_nwe",    wq.size(), 0);
        check("lone_addr_kept", 32'(bus.addr), 32'd4);

        check("pulse_width", bad_width, 0);
        check("valid_ferr_overlap", overlap, 0);
        check("we_without_valid", we_orphan, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
